// File: rtl/matrix_inv2x2_engine.sv
// matrix_inv2x2_engine
//   Sequential 2x2 signed fixed-point matrix inverter. One matrix is in
//   flight at a time: it computes det = a*d - b*c, then r = 1/|det| with a
//   serial restoring divider, then inv = r * [d -b; -c a] with saturation.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake; in_ready is high only when idle
//   in_a..in_d            matrix [[a,b],[c,d]], signed Q(W-FRAC).FRAC
//   out_valid / out_ready result handshake; result held until accepted
//   out_a..out_d          inverse elements, same Q format
//   singular              det was zero for the current result
//   ovf                   per-element saturation flags {d,c,b,a}
//   busy                  engine not idle
module matrix_inv2x2_engine #(
  parameter int W    = 16,
  parameter int FRAC = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [W-1:0] in_c,
  input  logic [W-1:0] in_d,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_a,
  output logic [W-1:0] out_b,
  output logic [W-1:0] out_c,
  output logic [W-1:0] out_d,
  output logic         singular,
  output logic [3:0]   ovf,
  output logic         busy
);

  localparam int DW = 2*W + 1;  // det and divider remainder width
  localparam int QW = 2*W;      // reciprocal width
  localparam int PW = 3*W + 1;  // element * reciprocal product width
  localparam int CW = $clog2(2*W);

  localparam logic [CW-1:0] LAST_CNT = CW'(2*W - 1);
  // The constant numerator 2^(3*FRAC) has a single set bit; this is the
  // iteration at which it is shifted into the remainder (MSB-first).
  localparam logic [CW-1:0] NUM_CNT  = CW'(2*W - 1 - 3*FRAC);

  localparam logic [PW-1:0] MAX_POS = PW'((64'd1 << (W-1)) - 64'd1);
  localparam logic [PW-1:0] MAX_NEG = PW'(64'd1 << (W-1));

  typedef enum logic [2:0] {IDLE, DET, DIV, MUL, DONE} state_t;

  state_t state, next_state;

  logic signed [W-1:0]  a_q, b_q, c_q, d_q;
  logic signed [DW-1:0] det_q;
  logic [DW-1:0]        det_mag, rem_q, rem_shift, rem_diff;
  logic [QW-1:0]        quot_q;
  logic [CW-1:0]        cnt_q;
  logic                 det_zero, rem_ge;
  logic signed [W:0]    x_a, x_b, x_c, x_d;
  logic [W:0]           res_a, res_b, res_c, res_d;

  // Scales one cofactor by the reciprocal and applies the sign of X*det.
  // Returns {saturated, value}.
  function automatic logic [W:0] scale(input logic signed [W:0] x,
                                       input logic det_neg,
                                       input logic [QW-1:0] r);
    logic [W:0]    ax;
    logic [PW-1:0] mag;
    ax  = x[W] ? $unsigned(-x) : $unsigned(x);
    mag = (PW'(ax) * PW'(r)) >> FRAC;
    if (x[W] ^ det_neg) begin
      if (mag > MAX_NEG) scale = {1'b1, 1'b1, {(W-1){1'b0}}};
      else               scale = {1'b0, W'(~mag + PW'(1))};
    end else begin
      if (mag > MAX_POS) scale = {1'b1, 1'b0, {(W-1){1'b1}}};
      else               scale = {1'b0, mag[W-1:0]};
    end
  endfunction

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);

  assign det_zero  = (det_q == '0);
  assign det_mag   = det_q[DW-1] ? $unsigned(-det_q) : $unsigned(det_q);
  assign rem_shift = {rem_q[DW-2:0], (cnt_q == NUM_CNT)};
  assign rem_ge    = (rem_shift >= det_mag);
  assign rem_diff  = rem_shift - det_mag;

  // Cofactors in W+1 bits so that negating -2^(W-1) stays exact.
  assign x_a = {d_q[W-1], d_q};
  assign x_b = -{b_q[W-1], b_q};
  assign x_c = -{c_q[W-1], c_q};
  assign x_d = {a_q[W-1], a_q};

  assign res_a = scale(x_a, det_q[DW-1], quot_q);
  assign res_b = scale(x_b, det_q[DW-1], quot_q);
  assign res_c = scale(x_c, det_q[DW-1], quot_q);
  assign res_d = scale(x_d, det_q[DW-1], quot_q);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic. The singular check happens on the first DIV cycle,
  // once det has been registered, so the singular path is a fixed 2 edges.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (in_valid) next_state = DET;
      DET:  next_state = DIV;
      DIV: begin
        if (cnt_q == '0 && det_zero) next_state = DONE;
        else if (cnt_q == LAST_CNT)  next_state = MUL;
      end
      MUL:  next_state = DONE;
      DONE: if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: operand capture, determinant, one quotient bit per DIV cycle,
  // and the result registers, which hold their value until the next update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      d_q      <= '0;
      det_q    <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      cnt_q    <= '0;
      out_a    <= '0;
      out_b    <= '0;
      out_c    <= '0;
      out_d    <= '0;
      singular <= 1'b0;
      ovf      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q <= in_a;
            b_q <= in_b;
            c_q <= in_c;
            d_q <= in_d;
          end
        end
        DET: begin
          det_q  <= (DW'(a_q) * DW'(d_q)) - (DW'(b_q) * DW'(c_q));
          rem_q  <= '0;
          quot_q <= '0;
          cnt_q  <= '0;
        end
        DIV: begin
          if (cnt_q == '0 && det_zero) begin
            singular <= 1'b1;
            out_a    <= '0;
            out_b    <= '0;
            out_c    <= '0;
            out_d    <= '0;
            ovf      <= '0;
          end else begin
            rem_q  <= rem_ge ? rem_diff : rem_shift;
            quot_q <= {quot_q[QW-2:0], rem_ge};
            cnt_q  <= cnt_q + CW'(1);
          end
        end
        MUL: begin
          out_a    <= res_a[W-1:0];
          out_b    <= res_b[W-1:0];
          out_c    <= res_c[W-1:0];
          out_d    <= res_d[W-1:0];
          ovf      <= {res_d[W], res_c[W], res_b[W], res_a[W]};
          singular <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
